triumph_pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the Triumph RV32I core. Sits beside the ID stage and consumes decoded register fields, a load flag from decode, the EX redirect and the data-memory handshake. It generates IF/ID stall, ID flush, EX bubble and a whole-pipe freeze. It keeps a load-destination scoreboard for load-use RAW hazards and a counter-based flush sequencer for taken branches and jumps.

---
 rtl/triumph_pipe_ctrl.sv | 150 +++++++++++++++
 tb/tb_triumph_pipe_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/triumph_pipe_ctrl.sv
// Pipeline sequencing controller for the Triumph RV32I core: load-use scoreboard,
// redirect flush sequencer and memory freeze. Optional perf counters: TRIUMPH_PIPE_PERF_EN.
module triumph_pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_rd_we_i,
  input  logic             id_is_load_i,
  input  logic             ex_redirect_i,
  input  logic             ex_mem_req_i,
  input  logic             mem_ready_i,
  input  logic             wb_load_we_i,
  input  logic [4:0]       wb_rd_i,
  output logic             if_stall_o,
  output logic             id_stall_o,
  output logic             ex_bubble_o,
  output logic             id_flush_o,
  output logic             freeze_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    RAW_STALL = 2'd1,
    FLUSH     = 2'd2,
    MEM_WAIT  = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [31:1] sb_q;
  logic [31:0] sb;
  logic [2:0]  flush_ctr_q;
  logic        freeze;
  logic        flush;
  logic        redirect_ok;
  logic        busy_rs1;
  logic        busy_rs2;
  logic        hit;
  logic        raw;
  logic        issue;
  logic        sb_set;

  assign sb          = {sb_q, 1'b0};
  assign freeze      = ex_mem_req_i & ~mem_ready_i;
  assign redirect_ok = ex_redirect_i & ~freeze;
  assign flush       = ~freeze & (ex_redirect_i | (flush_ctr_q != 3'd0));

  // Writeback of a load bypasses its own scoreboard bit in the same cycle.
  assign busy_rs1 = sb[id_rs1_i] & ~(wb_load_we_i & (wb_rd_i == id_rs1_i));
  assign busy_rs2 = sb[id_rs2_i] & ~(wb_load_we_i & (wb_rd_i == id_rs2_i));
  assign hit      = id_valid_i & ((id_rs1_used_i & busy_rs1) | (id_rs2_used_i & busy_rs2));
  assign raw      = hit & ~flush & ~freeze;
  assign issue    = id_valid_i & ~hit & ~flush & ~freeze;
  assign sb_set   = issue & id_is_load_i & id_rd_we_i & (id_rd_i != 5'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_q        <= '0;
      flush_ctr_q <= 3'd0;
    end else if (!freeze) begin
      if (ex_redirect_i) begin
        flush_ctr_q <= FLUSH_RELOAD;
      end else if (flush_ctr_q != 3'd0) begin
        flush_ctr_q <= flush_ctr_q - 3'd1;
      end
      // A new load to the register wins over a simultaneous writeback clear.
      for (int r = 1; r < 32; r++) begin
        sb_q[r] <= (sb_set & (id_rd_i == 5'(r))) |
                   (sb_q[r] & ~(wb_load_we_i & (wb_rd_i == 5'(r))));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = RUN;
    if (freeze) begin
      state_d = MEM_WAIT;
    end else if (flush) begin
      state_d = FLUSH;
    end else if (raw) begin
      state_d = RAW_STALL;
    end
  end

  always_comb begin
    if_stall_o  = 1'b0;
    id_stall_o  = 1'b0;
    ex_bubble_o = 1'b0;
    id_flush_o  = 1'b0;
    freeze_o    = 1'b0;
    state_o     = 2'd0;
    if (!rst_i) begin
      freeze_o    = freeze;
      if_stall_o  = freeze | raw;
      id_stall_o  = freeze | raw;
      ex_bubble_o = ~freeze & (raw | flush);
      id_flush_o  = flush;
      state_o     = state_q;
    end
  end

`ifdef TRIUMPH_PIPE_PERF_EN
  logic [CNT_W-1:0] stall_events_q;
  logic [CNT_W-1:0] flush_events_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_events_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (raw | freeze) begin
        stall_events_q <= stall_events_q + 1'b1;
      end
      if (redirect_ok) begin
        flush_events_q <= flush_events_q + 1'b1;
      end
    end
  end

  assign stall_cnt_o = rst_i ? '0 : stall_events_q;
  assign flush_cnt_o = rst_i ? '0 : flush_events_q;
`else
  logic unused_perf;
  assign unused_perf = redirect_ok;
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_triumph_pipe_ctrl.sv
// Directed self-checking bench for triumph_pipe_ctrl (FLUSH_CYCLES=2).
module tb_triumph_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_rd_we;
  logic        id_is_load;
  logic        ex_redirect;
  logic        ex_mem_req;
  logic        mem_ready;
  logic        wb_load_we;
  logic [4:0]  wb_rd;
  logic        if_stall;
  logic        id_stall;
  logic        ex_bubble;
  logic        id_flush;
  logic        freeze;
  logic [1:0]  state;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int numChecks = 0;
  int numFails  = 0;

  triumph_pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .id_rd_i(id_rd), .id_rd_we_i(id_rd_we), .id_is_load_i(id_is_load),
    .ex_redirect_i(ex_redirect), .ex_mem_req_i(ex_mem_req), .mem_ready_i(mem_ready),
    .wb_load_we_i(wb_load_we), .wb_rd_i(wb_rd),
    .if_stall_o(if_stall), .id_stall_o(id_stall), .ex_bubble_o(ex_bubble),
    .id_flush_o(id_flush), .freeze_o(freeze), .state_o(state),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    assert (observed === expected)
    else begin
      numFails++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Packed view of the five control outputs: {if_stall, id_stall, ex_bubble, id_flush, freeze}
  task automatic checkCtl(input string tag, input logic [4:0] expected);
    checkOutput(tag, {27'd0, if_stall, id_stall, ex_bubble, id_flush, freeze}, {27'd0, expected});
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] rs1, input logic rs1u,
                               input logic [4:0] rs2, input logic rs2u, input logic [4:0] rd,
                               input logic rdwe, input logic isload);
    id_valid = valid; id_rs1 = rs1; id_rs1_used = rs1u; id_rs2 = rs2; id_rs2_used = rs2u;
    id_rd = rd; id_rd_we = rdwe; id_is_load = isload;
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_we = 0; id_is_load = 0; ex_redirect = 0; ex_mem_req = 0;
    mem_ready = 1; wb_load_we = 0; wb_rd = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    // Reset with a pending freeze and redirect: every output is forced low.
    ex_mem_req = 1; mem_ready = 0; ex_redirect = 1;
    #1;
    checkCtl("reset_ctl", 5'b00000);
    checkOutput("reset_state", state, 0);
    step();
    idle();
    rst = 0;
    #1;
    checkOutput("post_reset_state", state, 0);
    checkOutput("post_reset_stall_cnt", stall_cnt, 0);
    checkOutput("post_reset_flush_cnt", flush_cnt, 0);
    checkCtl("post_reset_ctl", 5'b00000);

    // Test 1: load x5, then ADD x6,x5,x1 stalls until x5 writes back.
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1);
    checkCtl("t1_load_issue", 5'b00000);
    step();
    applyStimulus(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
    checkCtl("t1_raw_stall", 5'b11100);
    step();
    checkOutput("t1_state_raw", state, 1);
    checkCtl("t1_raw_stall_2", 5'b11100);
    wb_load_we = 1; wb_rd = 5'd5;
    #1;
    checkCtl("t1_wb_bypass", 5'b00000);
    step();
    wb_load_we = 0;
    #1;
    checkOutput("t1_state_run", state, 0);
    checkCtl("t1_x5_cleared", 5'b00000);
    step();

    // Test 2: load to x0 never marks the scoreboard.
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1);
    step();
    applyStimulus(1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0);
    checkCtl("t2_x0_no_stall", 5'b00000);
    step();

    // Test 5: new load of x7 coincides with writeback of old x7 load.
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    step();
    wb_load_we = 1; wb_rd = 5'd7;
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    checkCtl("t5_set_clear_issue", 5'b00000);
    step();
    wb_load_we = 0;
    applyStimulus(1, 5'd2, 1, 5'd7, 1, 5'd8, 1, 0);
    checkCtl("t5_x7_still_busy", 5'b11100);
    step();
    idle();
    wb_load_we = 1; wb_rd = 5'd7;
    step();
    idle();

    // Test 3: single redirect flushes exactly two cycles; load during flush is not tracked.
    ex_redirect = 1;
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1);
    checkCtl("t3_flush_c1", 5'b00110);
    step();
    ex_redirect = 0;
    applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    checkOutput("t3_state_flush", state, 2);
    checkCtl("t3_flush_c2", 5'b00110);
    step();
    checkCtl("t3_flush_done", 5'b00000);
    applyStimulus(1, 5'd9, 1, 5'd0, 0, 5'd4, 1, 0);
    checkCtl("t3_x9_not_busy", 5'b00000);
    step();
    idle();
    // Second redirect in cycle 2 extends the flush to three cycles.
    ex_redirect = 1;
    #1;
    checkCtl("t3b_c1", 5'b00110);
    step();
    checkCtl("t3b_c2", 5'b00110);
    step();
    ex_redirect = 0;
    #1;
    checkCtl("t3b_c3", 5'b00110);
    step();
    checkCtl("t3b_c4", 5'b00000);
    step();

    // Test 4: four frozen cycles swallow a held redirect, then flush starts.
    ex_mem_req = 1; mem_ready = 0; ex_redirect = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkCtl($sformatf("t4_freeze_%0d", i), 5'b11001);
      step();
      if (i == 0) checkOutput("t4_state_mem_wait", state, 3);
    end
    mem_ready = 1;
    #1;
    checkCtl("t4_flush_start", 5'b00110);
    step();
    idle();
    #1;
    checkCtl("t4_flush_c2", 5'b00110);
    step();
    checkCtl("t4_flush_done", 5'b00000);

    // Test 6a: reset during flush aborts it.
    ex_redirect = 1;
    step();
    ex_redirect = 0;
    rst = 1;
    #1;
    checkCtl("t6_rst_in_flush", 5'b00000);
    step();
    rst = 0;
    #1;
    checkCtl("t6_flush_aborted", 5'b00000);
    checkOutput("t6a_state", state, 0);

    // Test 6b: reset during RAW stall clears the scoreboard.
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1);
    step();
    applyStimulus(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
    checkCtl("t6_raw_before_rst", 5'b11100);
    rst = 1;
    #1;
    checkCtl("t6_rst_in_raw", 5'b00000);
    step();
    rst = 0;
    #1;
    checkCtl("t6_sb_cleared", 5'b00000);
    checkOutput("t6b_state", state, 0);
    checkOutput("t6_stall_cnt", stall_cnt, 0);
    checkOutput("t6_flush_cnt", flush_cnt, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
